// File: rtl/sp_comma_align_pkg.sv
// Shared definitions for the serial K28.5 comma aligner: FSM encoding and comma patterns.
package sp_comma_align_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCK   = 2'd2
  } alignState_t;

  // K28.5 patterns with the first-received bit at bit 0.
  localparam logic [9:0] K28_5_N = 10'h17C;
  localparam logic [9:0] K28_5_P = 10'h283;

endpackage

// File: rtl/sp_shift_window.sv
// Serial-to-parallel window with comma comparator.
// New bits enter at the MSB, so the oldest bit of the window ends up at bit 0.
module sp_shift_window
  import sp_comma_align_pkg::*;
#(
  parameter int               WIDTH   = 10,
  parameter logic [WIDTH-1:0] COMMA_N = WIDTH'(K28_5_N),
  parameter logic [WIDTH-1:0] COMMA_P = WIDTH'(K28_5_P)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_serial_in,
  output logic [WIDTH-1:0] o_window,
  output logic             o_match
);

  logic [WIDTH-1:0] r_window;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_window <= '0;
    end else begin
      r_window <= {i_serial_in, r_window[WIDTH-1:1]};
    end
  end

  assign o_window = r_window;
  assign o_match  = (r_window == COMMA_N) || (r_window == COMMA_P);

endmodule

// File: rtl/sp_comma_align.sv
// Serial comma aligner: finds the K28.5 symbol boundary, locks after LOCK_COUNT
// consecutive aligned commas, then emits one parallel symbol every WIDTH bits.
module sp_comma_align
  import sp_comma_align_pkg::*;
#(
  parameter int               WIDTH      = 10,
  parameter int               LOCK_COUNT = 3,
  parameter logic [WIDTH-1:0] COMMA_N    = WIDTH'(K28_5_N),
  parameter logic [WIDTH-1:0] COMMA_P    = WIDTH'(K28_5_P)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_serial_in,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_valid,
  output logic             o_comma_det,
  output logic             o_locked,
  output logic [7:0]       o_realign_cnt
);

  localparam int         PW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] W_LOCK = 4'(LOCK_COUNT);

  logic [WIDTH-1:0] w_window;
  logic             w_match;
  logic             w_boundary;
  logic             w_load;
  logic             w_loseLock;
  logic [3:0]       w_countInc;
  logic [3:0]       w_nextCount;
  alignState_t      w_nextState;

  logic [PW-1:0]    r_phase;
  logic [3:0]       r_commaCount;
  alignState_t      r_state;
  logic [WIDTH-1:0] r_dataOut;
  logic             r_valid;
  logic             r_commaDet;
  logic             r_locked;
  logic [7:0]       r_realignCnt;

  sp_shift_window #(
    .WIDTH   (WIDTH),
    .COMMA_N (COMMA_N),
    .COMMA_P (COMMA_P)
  ) u_window (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_serial_in (i_serial_in),
    .o_window    (w_window),
    .o_match     (w_match)
  );

  // Any match restarts the phase; a match on a boundary coincides with the natural wrap.
  assign w_boundary = (r_phase == PW'(WIDTH - 1));
  assign w_countInc = r_commaCount + 4'd1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= '0;
    end else if (w_match || w_boundary) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + PW'(1);
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_commaCount;
    w_load      = 1'b0;
    w_loseLock  = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_match) begin
          w_nextCount = 4'd1;
          w_nextState = (LOCK_COUNT == 1) ? LOCK : ALIGN;
        end
      end
      ALIGN: begin
        if (w_boundary) begin
          if (w_match) begin
            w_nextCount = w_countInc;
            if (w_countInc >= W_LOCK) w_nextState = LOCK;
          end else begin
            w_nextCount = 4'd0;
            w_nextState = SEARCH;
          end
        end else if (w_match) begin
          w_nextCount = 4'd1;
        end
      end
      LOCK: begin
        if (w_boundary) begin
          w_load = 1'b1;
        end else if (w_match) begin
          w_loseLock  = 1'b1;
          w_nextCount = 4'd1;
          w_nextState = ALIGN;
        end
      end
      default: begin
        w_nextCount = 4'd0;
        w_nextState = SEARCH;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= SEARCH;
      r_commaCount <= 4'd0;
    end else begin
      r_state      <= w_nextState;
      r_commaCount <= w_nextCount;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dataOut    <= '0;
      r_valid      <= 1'b0;
      r_commaDet   <= 1'b0;
      r_locked     <= 1'b0;
      r_realignCnt <= 8'd0;
    end else begin
      r_valid    <= w_load;
      r_commaDet <= w_load && w_match;
      r_locked   <= (w_nextState == LOCK);
      if (w_load) r_dataOut <= w_window;
      if (w_loseLock && (r_realignCnt != 8'hFF)) r_realignCnt <= r_realignCnt + 8'd1;
    end
  end

  assign o_data_out    = r_dataOut;
  assign o_valid       = r_valid;
  assign o_comma_det   = r_commaDet;
  assign o_locked      = r_locked;
  assign o_realign_cnt = r_realignCnt;

endmodule

// File: tb/tb_sp_comma_align.sv
// Self-checking bench for sp_comma_align: directed alignment scenarios plus random
// traffic, every cycle compared against a bit-level behavioural model.
module tb_sp_comma_align;

   localparam int         W   = 10;
   localparam int         LC  = 3;
   localparam logic [9:0] CN  = 10'h17C;
   localparam logic [9:0] CP  = 10'h283;
   localparam logic [9:0] DAT = 10'h0AA;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_serial_in = 1'b0;
   logic [9:0] o_data_out;
   logic       o_valid;
   logic       o_comma_det;
   logic       o_locked;
   logic [7:0] o_realign_cnt;

   int vectorCount = 0;
   int missCount = 0;

   // Model state: recent bit history, where the boundary was last anchored, and what phase we are in.
   logic [9:0] mWin;
   int         mCycle;
   int         mAnchor;
   int         mCount;
   bit         mInAlign;
   bit         mInLock;
   logic [9:0] eData;
   logic       eValid;
   logic       eComma;
   logic       eLocked;
   logic [7:0] eRealign;

   int validSeen;
   bit allComma;

   sp_comma_align dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_serial_in   (i_serial_in),
      .o_data_out    (o_data_out),
      .o_valid       (o_valid),
      .o_comma_det   (o_comma_det),
      .o_locked      (o_locked),
      .o_realign_cnt (o_realign_cnt)
   );

   always #5 i_clk = ~i_clk;

   // Single comparison point for every check in this bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] dutWord();
      return {11'd0, o_data_out, o_valid, o_comma_det, o_locked, o_realign_cnt};
   endfunction

   function automatic logic [31:0] modelWord();
      return {11'd0, eData, eValid, eComma, eLocked, eRealign};
   endfunction

   task automatic modelReset();
      mWin = '0; mCycle = 0; mAnchor = 0; mCount = 0;
      mInAlign = 0; mInLock = 0;
      eData = '0; eValid = 0; eComma = 0; eLocked = 0; eRealign = '0;
   endtask

   // Applies the alignment rules to the window as it stands before the edge, then shifts in b.
   task automatic modelStep(input logic b);
      bit match, boundary, tracking;
      match    = (mWin == CN) || (mWin == CP);
      tracking = mInAlign || mInLock;
      boundary = tracking && (mCycle != mAnchor) && (((mCycle - mAnchor) % W) == 0);
      eValid = 0;
      eComma = 0;
      if (mInLock && boundary) begin
         eData  = mWin;
         eValid = 1;
         eComma = match;
      end else if (tracking && match && !boundary) begin
         if (mInLock && eRealign != 8'hFF) eRealign = eRealign + 8'd1;
         mInLock = 0; mInAlign = 1; mCount = 1; mAnchor = mCycle;
      end else if (mInAlign && boundary) begin
         if (match) begin
            mCount++;
            if (mCount >= LC) begin mInAlign = 0; mInLock = 1; end
         end else begin
            mInAlign = 0; mCount = 0;
         end
      end else if (!tracking && match) begin
         mCount = 1; mAnchor = mCycle;
         if (LC == 1) mInLock = 1; else mInAlign = 1;
      end
      eLocked = mInLock;
      mWin = {b, mWin[9:1]};
      mCycle++;
   endtask

   // Drives one bit just after an edge, lets one rising edge sample it, then compares.
   task automatic applyStimulus(input logic b);
      i_serial_in = b;
      modelStep(b);
      @(posedge i_clk);
      #1;
      checkOutput("cycle", dutWord(), modelWord());
      if (o_valid) begin
         validSeen++;
         if (!o_comma_det) allComma = 0;
      end
   endtask

   task automatic sendBits(input logic [9:0] sym, input int from);
      for (int i = from; i < W; i++) applyStimulus(sym[i]);
   endtask

   task automatic sendSymbol(input logic [9:0] sym);
      sendBits(sym, 0);
   endtask

   // Asynchronous reset between edges; outputs must clear without any clock edge.
   task automatic doReset();
      i_rst = 1'b1;
      #2;
      modelReset();
      checkOutput("reset_async", dutWord(), 32'd0);
      i_rst = 1'b0;
   endtask

   initial begin
      logic [9:0] sym;
      int kind;

      modelReset();
      @(posedge i_clk);
      #1;
      doReset();

      // Comma then non-comma at the boundary: must fall back to search, never output.
      validSeen = 0;
      sendSymbol(CN);
      sendSymbol(DAT);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0);
      checkOutput("align_miss_locked", 32'(o_locked), 32'd0);
      checkOutput("align_miss_valid", 32'(validSeen), 32'd0);

      // Three aligned commas then a data symbol.
      doReset();
      sendSymbol(CN);
      sendSymbol(CN);
      sendSymbol(CN);
      checkOutput("locked_at_bit30", 32'(o_locked), 32'd0);
      sym = DAT;
      applyStimulus(sym[0]);
      checkOutput("locked_at_bit31", 32'(o_locked), 32'd1);
      sendBits(sym, 1);
      applyStimulus(1'b0);
      checkOutput("data_0aa", 32'(o_data_out), 32'h0AA);
      checkOutput("data_0aa_valid", 32'(o_valid), 32'd1);
      checkOutput("data_0aa_comma", 32'(o_comma_det), 32'd0);
      sendBits(CN, 1);

      // Comma three bits off phase while locked.
      for (int i = 0; i < 3; i++) applyStimulus(1'b0);
      sendSymbol(CN);
      applyStimulus(1'b0);
      checkOutput("rephase_locked", 32'(o_locked), 32'd0);
      checkOutput("rephase_realign", 32'(o_realign_cnt), 32'd1);
      sendBits(CN, 1);
      sendSymbol(CN);
      checkOutput("relock_early", 32'(o_locked), 32'd0);
      applyStimulus(1'b0);
      checkOutput("relock", 32'(o_locked), 32'd1);

      // Reset mid-symbol while locked, then a full relock sequence.
      sym = DAT;
      for (int i = 0; i < 4; i++) applyStimulus(sym[i]);
      doReset();
      sendSymbol(CN);
      sendSymbol(CN);
      sendSymbol(CN);
      checkOutput("post_reset_unlocked", 32'(o_locked), 32'd0);
      applyStimulus(1'b0);
      checkOutput("post_reset_locked", 32'(o_locked), 32'd1);

      // Random pad bits then alternating-disparity commas.
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(1'($urandom_range(0, 1)));
      sendSymbol(CN);
      sendSymbol(CP);
      sendSymbol(CN);
      checkOutput("alt_before_lock", 32'(o_locked), 32'd0);
      validSeen = 0;
      allComma = 1;
      sym = CP;
      applyStimulus(sym[0]);
      checkOutput("alt_locked", 32'(o_locked), 32'd1);
      sendBits(sym, 1);
      sendSymbol(CN);
      sendSymbol(CP);
      applyStimulus(1'b0);
      checkOutput("alt_valid_count", 32'(validSeen), 32'd3);
      checkOutput("alt_all_comma", 32'(allComma), 32'd1);

      // Random traffic mixing noise, lone commas and comma bursts.
      for (int n = 0; n < 200; n++) begin
         kind = int'($urandom_range(0, 3));
         case (kind)
            0: for (int i = 0; i < int'($urandom_range(1, 12)); i++) applyStimulus(1'($urandom_range(0, 1)));
            1: sendSymbol($urandom_range(0, 1) ? CN : CP);
            2: begin sendSymbol(CN); sendSymbol(CP); sendSymbol(CN); end
            default: sendSymbol(10'($urandom));
         endcase
      end

      // Repeated forced loss of lock until the counter saturates.
      doReset();
      sendSymbol(CN);
      sendSymbol(CN);
      sendSymbol(CN);
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 3; i++) applyStimulus(1'b0);
         sendSymbol(CN);
         sendSymbol(CN);
         sendSymbol(CN);
      end
      applyStimulus(1'b0);
      checkOutput("realign_saturated", 32'(o_realign_cnt), 32'hFF);
      checkOutput("saturate_locked", 32'(o_locked), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/sp_comma_align.md
SP_COMMA_ALIGN -- requirements
Module: sp_comma_align

Interface
REQ-001 Parameter WIDTH, default 10, symbol width in bits; legal range 4..16.
REQ-002 Parameter LOCK_COUNT, default 3, number of consecutive aligned commas needed to declare lock; legal range 1..15.
REQ-003 Parameter COMMA_N, default 10'h17C, K28.5 running-disparity-negative pattern, WIDTH bits, first-received bit at bit 0.
REQ-004 Parameter COMMA_P, default 10'h283, K28.5 running-disparity-positive pattern, WIDTH bits, first-received bit at bit 0.
REQ-005 CLOCK  input  1  single bit-rate clock; all state changes on the rising edge.
REQ-006 RESET  input  1  asynchronous, active-high reset.
REQ-007 SERIAL_IN  input  1  serial bit stream, one bit sampled per CLOCK rising edge.
REQ-008 DATA_OUT  output  WIDTH  last aligned symbol; first-received bit at bit 0.
REQ-009 VALID  output  1  one-cycle pulse each time DATA_OUT is loaded with a new symbol.
REQ-010 COMMA_DET  output  1  one-cycle pulse marking a DATA_OUT symbol equal to COMMA_N or COMMA_P.
REQ-011 LOCKED  output  1  high while the state machine is in LOCK.
REQ-012 REALIGN_CNT  output  8  saturating count of loss-of-lock events.

Function
REQ-013 Each edge, a WIDTH-bit window shifts right and SERIAL_IN enters at bit WIDTH-1, so after WIDTH shifts the first-received bit sits at bit 0.
REQ-014 A window match is a cycle in which the registered window equals COMMA_N or COMMA_P.
REQ-015 The state machine SHALL have exactly three states: SEARCH, ALIGN and LOCK.
REQ-016 In SEARCH, a window match sets the symbol-boundary phase to that cycle, loads the comma count with 1, and moves to ALIGN; if LOCK_COUNT=1, it moves directly to LOCK.
REQ-017 After the boundary phase is set, a boundary cycle occurs every WIDTH cycles.
REQ-018 In ALIGN, a boundary cycle with a window match increments the comma count; on reaching LOCK_COUNT, the state moves to LOCK.
REQ-019 In ALIGN, a boundary cycle without a window match returns the state to SEARCH and clears the comma count.
REQ-020 In ALIGN or LOCK, a window match on a non-boundary cycle re-phases the boundary to that cycle, loads the comma count with 1, and enters ALIGN.
REQ-021 A loss of lock is a REQ-020 event taken from LOCK; it increments REALIGN_CNT, which saturates at 8'hFF.
REQ-022 Boundary cycles in LOCK load DATA_OUT with the window at the next edge and pulse VALID for that one cycle; latency is 1 cycle after the last bit of the symbol is sampled.
REQ-023 COMMA_DET pulses together with VALID when the loaded symbol is a comma.
REQ-024 Outside LOCK, DATA_OUT holds its value and VALID and COMMA_DET stay low.
REQ-025 LOCKED is registered and rises on the same edge that first enters LOCK.
REQ-026 LOCKED falls on the edge that leaves LOCK.
REQ-027 A boundary cycle in LOCK is handled per REQ-022 and REQ-023; a non-comma symbol in LOCK keeps the state in LOCK.
REQ-028 A simultaneous boundary and match in LOCK is an aligned comma: it is output, with no re-phase and no loss of lock.

Reset
REQ-029 While RESET is high: window=0, DATA_OUT=0, VALID=0, COMMA_DET=0, LOCKED=0, REALIGN_CNT=0, comma count=0, state=SEARCH.
REQ-030 Assertion of RESET takes effect immediately, independent of CLOCK, including mid-symbol and while in LOCK.
REQ-031 The first sample after reset is taken on the first rising edge with RESET low.

Structure
REQ-032 A shared package SHALL hold the state encoding (SEARCH=2'd0, ALIGN=2'd1, LOCK=2'd2) and the K28.5 constants 10'h17C and 10'h283; the parameters default to these constants.
REQ-033 One sub-module, sp_shift_window, SHALL be used; it contains the WIDTH-bit shift register and the comma comparator producing the match flag.
REQ-034 Phase counter, state machine, output registers and REALIGN_CNT SHALL reside in sp_comma_align.

Verification
REQ-035 The bench SHALL cover, at defaults, reset then three 10'h17C symbols LSB-first followed by 10'h0AA: LOCKED rises one edge after the 30th bit, then DATA_OUT=10'h0AA with VALID=1 and COMMA_DET=0 one cycle after the 40th bit.
REQ-036 The bench SHALL cover 5 random pad bits before alternating 10'h17C/10'h283 commas: lock after the third comma, with every output symbol flagged COMMA_DET=1.
REQ-037 The bench SHALL cover, while locked, a 10'h17C inserted 3 bits off-phase: LOCKED falls, REALIGN_CNT=1, and lock is regained after two further aligned commas.
REQ-038 The bench SHALL cover, in ALIGN after one comma, a non-comma symbol at the boundary: the state returns to SEARCH, LOCKED stays 0, and VALID is never asserted.
REQ-039 The bench SHALL cover RESET pulsed mid-symbol while locked: all outputs are 0 immediately and a full three-comma sequence is required to relock.
REQ-040 The bench SHALL cover 300 forced loss-of-lock events: REALIGN_CNT saturates at 8'hFF.
